// File: rtl/priority_event_encoder_pkg.sv
// Shared types and helpers for the registered priority event encoder.
// Holds the handshake FSM state encoding and the one-hot to index conversion.
package prio_enc_pkg;

    localparam int MAX_N     = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // OR-reduction encoder: valid only for a one-hot (or all-zero) input.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/priority_event_encoder_find_first.sv
// Combinational lowest-set-bit finder: reports whether any bit is set and the
// index of the lowest one.
module prio_find_first
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] lowest;

    // Two's-complement trick isolates the lowest set bit as a one-hot.
    assign lowest = vec & (~vec + N'(1));
    assign found  = |vec;
    assign idx    = W'(onehot_to_idx(MAX_N'(lowest)));

endmodule

// File: rtl/priority_event_encoder.sv
// Sticky event capture with fixed-priority or round-robin issue of one index
// per valid/ready handshake; all outputs are registered.
module priority_event_encoder
    import prio_enc_pkg::*;
#(
    parameter  int N           = 8,
    parameter  int ROUND_ROBIN = 0,
    localparam int W           = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         overflow
);

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] load_mask;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         overflow_q, overflow_d;
    logic         load;
    logic         sel_found;
    logic [W-1:0] sel_idx;

    if (ROUND_ROBIN != 0) begin : g_rr
        logic [W-1:0] ptr_q, ptr_d;
        logic [N-1:0] ge_mask;
        logic         m_found, a_found;
        logic [W-1:0] m_idx, a_idx;

        always_comb begin
            ge_mask = '0;
            for (int i = 0; i < N; i++) begin
                ge_mask[i] = (i >= int'(ptr_q));
            end
        end

        prio_find_first #(.N(N), .W(W)) u_masked (
            .vec   (pending_q & ge_mask),
            .found (m_found),
            .idx   (m_idx)
        );

        prio_find_first #(.N(N), .W(W)) u_all (
            .vec   (pending_q),
            .found (a_found),
            .idx   (a_idx)
        );

        // Search from ptr upward first, then wrap to the lowest set bit.
        assign sel_found = a_found;
        assign sel_idx   = m_found ? m_idx : a_idx;

        always_comb begin
            ptr_d = ptr_q;
            if (load) begin
                ptr_d = (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_fixed
        prio_find_first #(.N(N), .W(W)) u_all (
            .vec   (pending_q),
            .found (sel_found),
            .idx   (sel_idx)
        );
    end

    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A held index is never re-selected until the consumer takes it.
                if (out_ready) begin
                    if (sel_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_idx_d = sel_idx;
        end
    end

    // A request landing on the bit being loaded re-arms it (set wins).
    always_comb begin
        load_mask  = load ? (N'(1) << sel_idx) : '0;
        pending_d  = (pending_q & ~load_mask) | req;
        overflow_d = |(req & pending_q & ~load_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            out_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            out_idx_q  <= out_idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_priority_event_encoder.sv
// Bench for priority_event_encoder: a fixed-priority N=8 instance and a
// round-robin N=5 instance driven side by side against a behavioural model.
module tb_priority_event_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req_fx;
    logic       rdy_fx;
    logic       vld_fx;
    logic [2:0] idx_fx;
    logic [7:0] pend_fx;
    logic       ovf_fx;
    logic [4:0] req_rr;
    logic       rdy_rr;
    logic       vld_rr;
    logic [2:0] idx_rr;
    logic [4:0] pend_rr;
    logic       ovf_rr;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [63:0] mf_pend, mr_pend;
    bit          mf_valid, mr_valid;
    int          mf_idx, mr_idx, mf_ptr, mr_ptr;
    bit          mf_ovf, mr_ovf;

    priority_event_encoder #(.N(8), .ROUND_ROBIN(0)) dut_fx (
        .clk       (clk),
        .rst       (rst),
        .req       (req_fx),
        .out_valid (vld_fx),
        .out_ready (rdy_fx),
        .out_idx   (idx_fx),
        .pending   (pend_fx),
        .overflow  (ovf_fx)
    );

    priority_event_encoder #(.N(5), .ROUND_ROBIN(1)) dut_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_rr),
        .out_valid (vld_rr),
        .out_ready (rdy_rr),
        .out_idx   (idx_rr),
        .pending   (pend_rr),
        .overflow  (ovf_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the specified behaviour: issue slot opens when idle or on accept;
    // selection is a circular search (from ptr in round-robin, from 0 otherwise).
    task automatic model_step(input int n, input bit rr, input logic [63:0] rq, input bit rdy,
                              inout logic [63:0] pend, inout bit valid, inout int idx,
                              inout int ptr, output bit ovf);
        bit accepted, loaded;
        int sel, j;
        accepted = valid && rdy;
        loaded   = 1'b0;
        sel      = 0;
        if ((!valid || accepted) && pend != 0) begin
            for (int k = 0; k < n; k++) begin
                j = rr ? (ptr + k) % n : k;
                if (!loaded && pend[j]) begin
                    loaded = 1'b1;
                    sel    = j;
                end
            end
        end
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rq[i] && pend[i] && !(loaded && i == sel)) ovf = 1'b1;
        end
        if (loaded) begin
            pend[sel] = 1'b0;
            idx       = sel;
            ptr       = (sel + 1) % n;
            valid     = 1'b1;
        end else if (accepted) begin
            valid = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            if (rq[i]) pend[i] = 1'b1;
        end
    endtask

    task automatic model_reset();
        mf_pend = '0; mf_valid = 0; mf_idx = 0; mf_ptr = 0; mf_ovf = 0;
        mr_pend = '0; mr_valid = 0; mr_idx = 0; mr_ptr = 0; mr_ovf = 0;
    endtask

    task automatic compare_all();
        check("fx_valid",   vld_fx,  mf_valid);
        check("fx_idx",     idx_fx,  mf_idx);
        check("fx_pending", pend_fx, mf_pend);
        check("fx_ovf",     ovf_fx,  mf_ovf);
        check("rr_valid",   vld_rr,  mr_valid);
        check("rr_idx",     idx_rr,  mr_idx);
        check("rr_pending", pend_rr, mr_pend);
        check("rr_ovf",     ovf_rr,  mr_ovf);
    endtask

    task automatic cycle(input logic [7:0] rf, input bit yf, input logic [4:0] rq_r, input bit yr);
        req_fx = rf;
        rdy_fx = yf;
        req_rr = rq_r;
        rdy_rr = yr;
        @(posedge clk);
        model_step(8, 1'b0, 64'(rf), yf, mf_pend, mf_valid, mf_idx, mf_ptr, mf_ovf);
        model_step(5, 1'b1, 64'(rq_r), yr, mr_pend, mr_valid, mr_idx, mr_ptr, mr_ovf);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fx_valid"}, vld_fx, 0);
        check({tag, "_fx_idx"},   idx_fx, 0);
        check({tag, "_fx_pend"},  pend_fx, 0);
        check({tag, "_fx_ovf"},   ovf_fx, 0);
        check({tag, "_rr_valid"}, vld_rr, 0);
        check({tag, "_rr_idx"},   idx_rr, 0);
        check({tag, "_rr_pend"},  pend_rr, 0);
        check({tag, "_rr_ovf"},   ovf_rr, 0);
    endtask

    int rr_exp[5] = '{0, 1, 4, 0, 1};
    int fx_seq[3] = '{2, 5, 7};

    initial begin
        rst    = 1'b1;
        req_fx = '0; rdy_fx = 1'b0;
        req_rr = '0; rdy_rr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // fixed priority, consumer always ready
        cycle(8'b1010_0100, 1, 0, 1);
        check("t1_pend", pend_fx, 8'hA4);
        check("t1_vld0", vld_fx, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 1);
            check("t1_vld", vld_fx, 1);
            check("t1_idx", idx_fx, fx_seq[i]);
        end
        cycle(0, 1, 0, 1);
        check("t1_done_vld", vld_fx, 0);
        check("t1_done_pend", pend_fx, 0);

        // stall while a later higher-priority request arrives
        cycle(8'h80, 0, 0, 1);
        cycle(8'h01, 0, 0, 1);
        check("t2_idx7", idx_fx, 7);
        cycle(0, 0, 0, 1);
        check("t2_hold_idx", idx_fx, 7);
        check("t2_hold_vld", vld_fx, 1);
        cycle(0, 1, 0, 1);
        check("t2_next_idx", idx_fx, 0);
        cycle(0, 1, 0, 1);
        check("t2_done_vld", vld_fx, 0);

        // duplicate request on a pending bit while the issuer is busy
        cycle(8'h01, 0, 0, 1);
        cycle(8'h08, 0, 0, 1);
        check("t3_ovf0", ovf_fx, 0);
        cycle(8'h08, 0, 0, 1);
        check("t3_ovf1", ovf_fx, 1);
        cycle(0, 0, 0, 1);
        check("t3_ovf_pulse", ovf_fx, 0);
        cycle(0, 1, 0, 1);
        check("t3_idx3", idx_fx, 3);
        cycle(0, 1, 0, 1);
        check("t3_once", vld_fx, 0);

        // request on the bit being loaded re-arms it
        cycle(8'h04, 1, 0, 1);
        cycle(8'h04, 1, 0, 1);
        check("t4_pend", pend_fx, 8'h04);
        check("t4_ovf", ovf_fx, 0);
        check("t4_idx_a", idx_fx, 2);
        cycle(0, 1, 0, 1);
        check("t4_idx_b", idx_fx, 2);
        check("t4_vld_b", vld_fx, 1);
        cycle(0, 1, 0, 1);
        check("t4_done", vld_fx, 0);

        // round robin, N=5, pending held at 10011
        cycle(0, 1, 5'b10011, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 5'b10011, 1);
            check("t5_rr_vld", vld_rr, 1);
            check("t5_rr_idx", idx_rr, rr_exp[i]);
        end
        repeat (6) cycle(0, 1, 0, 1);
        check("t5_rr_drained", vld_rr, 0);

        // asynchronous reset while holding with pending=F0
        cycle(8'hF1, 0, 5'b00110, 0);
        cycle(0, 0, 0, 0);
        check("t6_pre_vld", vld_fx, 1);
        check("t6_pre_pend", pend_fx, 8'hF0);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("t6_async");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cycle(0, 1, 0, 1);
        check("t6_no_grant", vld_fx, 0);

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            cycle(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00,
                  $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
